st_chan_adapter_pipe: RTL and testbench

ST_CHAN_ADAPTER_PIPE -- requirements
Module: st_chan_adapter_pipe

---
 rtl/st_adapter_pkg.sv | 13 +
 rtl/st_skid_buf.sv | 72 +++++++
 rtl/st_chan_adapter_pipe.sv | 129 ++++++++++++
 tb/tb_st_chan_adapter_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_adapter_pkg.sv
// Shared definitions for the streaming channel adapter: packet FSM encoding
// and drop-counter width.
package st_adapter_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/st_skid_buf.sv
// Two-entry ready/valid buffer (output register + skid register) whose
// in_ready is registered, so out_ready never reaches in_ready combinationally.
module st_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_ready_q, in_ready_d;
  logic         push_c, pop_c;

  assign push_c = in_valid && in_ready_q;
  assign pop_c  = out_valid_q && out_ready;

  // The output register always holds the oldest beat; the skid only fills
  // when a push meets a stalled, occupied output register.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (pop_c) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (push_c) begin
      if (!out_valid_q || pop_c) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (pop_c) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/st_chan_adapter_pipe.sv
// Streaming channel adapter: remaps in_channel by a fixed offset, forwards
// in-range packets through a skid buffer and discards out-of-range ones.
module st_chan_adapter_pipe
  import st_adapter_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IN_CHAN_W   = 8,
  parameter int unsigned OUT_CHAN_W  = 2,
  parameter int unsigned MAX_CHANNEL = 3,
  parameter int unsigned CHAN_OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [DROP_CNT_W-1:0] drop_count,
  input  logic                  drop_clear,
  output logic                  proto_err
);

  localparam int unsigned MAP_W = IN_CHAN_W + 1;
  localparam int unsigned PAY_W = DATA_W + OUT_CHAN_W + 2;

  pkt_state_e              state_q, state_d;
  logic [OUT_CHAN_W-1:0]   chan_q, chan_d;
  logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
  logic                    proto_err_q, proto_err_d;

  logic                    accept_c, in_range_c, fwd_c, drop_inc_c, err_c;
  logic [MAP_W-1:0]        mapped_c;
  logic [OUT_CHAN_W-1:0]   map_chan_c, fwd_chan_c;
  logic [PAY_W-1:0]        fwd_pay_c, out_pay_c;

  // Extra top bit turns the subtraction borrow into a sign flag.
  assign mapped_c   = MAP_W'(in_channel) - MAP_W'(CHAN_OFFSET);
  assign in_range_c = !mapped_c[IN_CHAN_W] &&
                      (mapped_c[IN_CHAN_W-1:0] <= IN_CHAN_W'(MAX_CHANNEL));
  assign map_chan_c = OUT_CHAN_W'(mapped_c[IN_CHAN_W-1:0]);
  assign accept_c   = in_valid && in_ready;

  // A SOP always restarts packet evaluation, whatever state we are in.
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    fwd_c      = 1'b0;
    fwd_chan_c = chan_q;
    drop_inc_c = 1'b0;
    err_c      = 1'b0;
    if (accept_c) begin
      if (in_startofpacket) begin
        err_c = (state_q != ST_IDLE);
        if (in_range_c) begin
          fwd_c      = 1'b1;
          fwd_chan_c = map_chan_c;
          chan_d     = map_chan_c;
          state_d    = in_endofpacket ? ST_IDLE : ST_PASS;
        end else begin
          drop_inc_c = 1'b1;
          state_d    = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else begin
        unique case (state_q)
          ST_PASS: begin
            fwd_c = 1'b1;
            if (in_endofpacket) state_d = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) state_d = ST_IDLE;
          end
          default: err_c = 1'b1;
        endcase
      end
    end

    drop_count_d = drop_count_q;
    proto_err_d  = proto_err_q;
    if (drop_clear) begin
      drop_count_d = '0;
      proto_err_d  = 1'b0;
    end else begin
      if (drop_inc_c && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_CNT_W'(1);
      if (err_c) proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      drop_count_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      drop_count_q <= drop_count_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign fwd_pay_c = {in_startofpacket, in_endofpacket, fwd_chan_c, in_data};

  st_skid_buf #(
    .W (PAY_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (fwd_c),
    .in_ready  (in_ready),
    .in_data   (fwd_pay_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay_c)
  );

  assign {out_startofpacket, out_endofpacket, out_channel, out_data} = out_pay_c;
  assign drop_count = drop_count_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_st_chan_adapter_pipe.sv
// Bench for st_chan_adapter_pipe: table vectors, directed packet sequences
// and randomized traffic checked against a packet-level reference model.
module tb_st_chan_adapter_pipe;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_startofpacket, in_endofpacket;
  logic [7:0]  in_data, in_channel;
  logic        in_ready, off_in_ready;
  logic        out_valid, out_ready, out_startofpacket, out_endofpacket;
  logic [7:0]  out_data;
  logic [1:0]  out_channel;
  logic [15:0] drop_count;
  logic        drop_clear, proto_err;
  logic        off_out_valid, off_sop, off_eop, off_proto_err;
  logic        off_out_ready;
  logic [7:0]  off_out_data;
  logic [1:0]  off_out_channel;
  logic [15:0] off_drop_count;

  int   ready_mode;
  logic ready_manual, ready_gen;
  int   vectors, miscompares, out_beats;
  bit   mon_en;

  always #5 clk = ~clk;

  assign out_ready     = (ready_mode == 0) ? ready_manual : ready_gen;
  assign off_out_ready = 1'b1;

  st_chan_adapter_pipe u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_channel(in_channel),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_channel(out_channel),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .drop_count(drop_count), .drop_clear(drop_clear), .proto_err(proto_err)
  );

  st_chan_adapter_pipe #(.CHAN_OFFSET(4)) u_off (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(off_in_ready), .in_data(in_data), .in_channel(in_channel),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_valid(off_out_valid), .out_ready(off_out_ready), .out_data(off_out_data),
    .out_channel(off_out_channel), .out_startofpacket(off_sop), .out_endofpacket(off_eop),
    .drop_count(off_drop_count), .drop_clear(drop_clear), .proto_err(off_proto_err)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) ready_gen = ~ready_gen;
    else ready_gen = 1'($urandom_range(0, 1));
  end

  // Reference model: expected forwarded beats in arrival order, packet mode,
  // drop count and error flag derived from the adapter's packet rules.
  typedef struct packed { logic sop; logic eop; logic [1:0] chan; logic [7:0] data; } beat_t;
  beat_t       exp_q[$];
  int          m_mode;   // 0 between packets, 1 forwarding, 2 discarding
  logic [1:0]  m_chan;
  logic [15:0] m_cnt;
  logic        m_err;
  bit          prev_hold;
  logic [11:0] prev_out;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_mode = 0; m_chan = 2'd0; m_cnt = 16'd0; m_err = 1'b0; prev_hold = 0;
    end else if (mon_en) begin
      int    mapped;
      beat_t b, got;
      chk("occupancy_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready_vs_skid", 32'(in_ready), 32'(exp_q.size() < 2));
      chk("drop_count", 32'(drop_count), 32'(m_cnt));
      chk("proto_err", 32'(proto_err), 32'(m_err));
      got = {out_startofpacket, out_endofpacket, out_channel, out_data};
      if (prev_hold) chk("stall_stable", {20'd0, out_valid, 11'(got)}, {20'd0, 1'b1, prev_out[10:0]});
      prev_hold = out_valid && !out_ready;
      prev_out  = 12'(got);
      if (out_valid && out_ready) begin
        out_beats++;
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
        else chk("out_beat", 32'(got), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        mapped = int'(in_channel);
        if (in_startofpacket) begin
          if (m_mode != 0) m_err = 1'b1;
          if (mapped >= 0 && mapped <= MAXC) begin
            m_chan = 2'(mapped);
            b = {1'b1, in_endofpacket, m_chan, in_data};
            exp_q.push_back(b);
            m_mode = in_endofpacket ? 0 : 1;
          end else begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_mode = in_endofpacket ? 0 : 2;
          end
        end else if (m_mode == 1) begin
          b = {1'b0, in_endofpacket, m_chan, in_data};
          exp_q.push_back(b);
          if (in_endofpacket) m_mode = 0;
        end else if (m_mode == 2) begin
          if (in_endofpacket) m_mode = 0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (drop_clear) begin m_cnt = 16'd0; m_err = 1'b0; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was taken.
  task automatic send(input logic sop, input logic eop, input logic [7:0] ch, input logic [7:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1; in_startofpacket = sop; in_endofpacket = eop;
    in_channel = ch; in_data = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
  endtask

  task automatic clear_pulse();
    drop_clear = 1'b1;
    cyc(1);
    drop_clear = 1'b0;
  endtask

  task automatic flush();
    bit empty;
    empty = 0;
    ready_mode = 0; ready_manual = 1'b1;
    for (int i = 0; i < 32 && !empty; i++) begin
      cyc(1);
      empty = (exp_q.size() == 0) && !out_valid;
    end
    if (!empty) chk("flush_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  data;
    logic        fwd;
    logic [1:0]  chan;
    logic [15:0] cnt;
  } vec_t;
  vec_t vt[8];

  initial begin
    int base;
    vt[0] = '{8'd0,   8'h11, 1'b1, 2'd0, 16'd0};
    vt[1] = '{8'd3,   8'h22, 1'b1, 2'd3, 16'd0};
    vt[2] = '{8'd4,   8'h33, 1'b0, 2'd0, 16'd1};
    vt[3] = '{8'd255, 8'h44, 1'b0, 2'd0, 16'd2};
    vt[4] = '{8'd2,   8'h55, 1'b1, 2'd2, 16'd2};
    vt[5] = '{8'd1,   8'h66, 1'b1, 2'd1, 16'd2};
    vt[6] = '{8'd5,   8'h77, 1'b0, 2'd0, 16'd3};
    vt[7] = '{8'd128, 8'h88, 1'b0, 2'd0, 16'd4};

    vectors = 0; miscompares = 0; out_beats = 0; mon_en = 0;
    ready_mode = 0; ready_manual = 1'b1; ready_gen = 1'b0;
    reset_n = 1'b0; drop_clear = 1'b0;
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    in_data = 8'd0; in_channel = 8'd0;

    // Reset values, then in_ready rising on the first edge after release.
    cyc(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_out_fields", {20'd0, out_startofpacket, out_endofpacket, out_channel, out_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    cyc(1);
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);
    mon_en = 1;

    // Single-beat packets through the channel range check.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b1, vt[i].ch, vt[i].data);
      chk("tbl_valid", 32'(out_valid), 32'(vt[i].fwd));
      if (vt[i].fwd) begin
        chk("tbl_chan", 32'(out_channel), 32'(vt[i].chan));
        chk("tbl_data", 32'(out_data), 32'(vt[i].data));
        chk("tbl_sop_eop", 32'({out_startofpacket, out_endofpacket}), 32'd3);
      end
      chk("tbl_drop_count", 32'(drop_count), 32'(vt[i].cnt));
    end
    cyc(2);

    // Four-beat packet on channel 2, one-cycle latency, channel held.
    base = out_beats;
    send(1'b1, 1'b0, 8'd2, 8'hA0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_chan", 32'(out_channel), 32'd2);
    chk("lat_sop", 32'(out_startofpacket), 32'd1);
    send(1'b0, 1'b0, 8'd7, 8'hA1);
    send(1'b0, 1'b0, 8'd9, 8'hA2);
    send(1'b0, 1'b1, 8'd1, 8'hA3);
    chk("pkt4_last_chan", 32'(out_channel), 32'd2);
    cyc(3);
    chk("pkt4_beats", 32'(out_beats - base), 32'd4);

    // Dropped channel-5 packet followed by a forwarded channel-1 packet.
    clear_pulse();
    base = out_beats;
    send(1'b1, 1'b0, 8'd5, 8'hB0);
    send(1'b0, 1'b0, 8'd5, 8'hB1);
    send(1'b0, 1'b1, 8'd5, 8'hB2);
    send(1'b1, 1'b0, 8'd1, 8'hB3);
    send(1'b0, 1'b1, 8'd1, 8'hB4);
    cyc(3);
    chk("drop_pkt_beats", 32'(out_beats - base), 32'd2);
    chk("drop_pkt_count", 32'(drop_count), 32'd1);

    // Offset-4 instance: channel 3 underflows, channel 6 maps to 2.
    send(1'b1, 1'b1, 8'd3, 8'hC0);
    chk("off_neg_dropped", 32'(off_out_valid), 32'd0);
    send(1'b1, 1'b1, 8'd6, 8'hC1);
    chk("off_fwd_valid", 32'(off_out_valid), 32'd1);
    chk("off_fwd_chan", 32'(off_out_channel), 32'd2);
    chk("off_fwd_data", 32'(off_out_data), 32'hC1);
    cyc(2);

    // Protocol errors, clear, and clear coincident with a drop.
    clear_pulse();
    send(1'b1, 1'b0, 8'd1, 8'hD0);
    send(1'b1, 1'b0, 8'd2, 8'hD1);
    chk("err_sop_mid_pkt", 32'(proto_err), 32'd1);
    send(1'b0, 1'b1, 8'd2, 8'hD2);
    clear_pulse();
    chk("clear_err", 32'(proto_err), 32'd0);
    chk("clear_count", 32'(drop_count), 32'd0);
    send(1'b0, 1'b1, 8'd0, 8'hD3);
    chk("err_orphan", 32'(proto_err), 32'd1);
    send(1'b1, 1'b1, 8'd6, 8'hD4);
    chk("count_before_coincident", 32'(drop_count), 32'd1);
    drop_clear = 1'b1;
    send(1'b1, 1'b1, 8'd7, 8'hD5);
    drop_clear = 1'b0;
    chk("coincident_clear", 32'(drop_count), 32'd0);
    cyc(2);

    // Toggling out_ready: order kept, no loss, in_ready low only when full.
    base = out_beats;
    ready_mode = 2;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 5; k++)
        send(1'(k == 0), 1'(k == 4), 8'(p), 8'(16 * p + k));
    flush();
    chk("toggle_beats", 32'(out_beats - base), 32'd15);

    // Randomized traffic with random back-pressure and occasional clears.
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      drop_clear = 1'($urandom_range(0, 31) == 0);
      send(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 7)), 8'($urandom));
      drop_clear = 1'b0;
      if ($urandom_range(0, 3) == 0) cyc(1);
    end
    flush();

    // Reset with both buffer entries full mid-packet.
    ready_manual = 1'b0;
    send(1'b1, 1'b0, 8'd1, 8'hE0);
    send(1'b0, 1'b0, 8'd1, 8'hE1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    mon_en = 0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    mon_en = 1;
    ready_manual = 1'b1;
    base = out_beats;
    send(1'b1, 1'b1, 8'd0, 8'hE5);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_beat", 32'({out_startofpacket, out_endofpacket, out_channel, out_data}),
        32'({1'b1, 1'b1, 2'd0, 8'hE5}));
    cyc(2);
    chk("post_rst_beats", 32'(out_beats - base), 32'd1);
    chk("post_rst_err", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
